// File: rtl/upload_loader.sv
// Streams HPS download bytes through a small FIFO into single-byte SDRAM writes.
// Tracks completed writes and flags dropped bytes and unanswered requests.
module upload_loader #(
    parameter int                ADDR_W     = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 4,
    parameter int                TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic              ioctl_wait,
    output logic              upload,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_rnw,
    output logic              mem_ram_cs,
    input  logic              mem_sdram_ready,
    input  logic              mem_sdram_done,
    output logic [ADDR_W-1:0] bytes_written,
    output logic              overflow_err,
    output logic              timeout_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HIGH_WATER = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

    state_t              state_reg;
    logic [ADDR_W+7:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic                download_d_reg;

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                download_rise;
    logic [ADDR_W-1:0]   push_addr;

    assign fifo_full     = (count_reg == DEPTH_C);
    assign fifo_empty    = (count_reg == '0);
    assign push          = ioctl_wr && ioctl_download && !fifo_full;
    assign pop           = (state_reg == IDLE) && upload && !fifo_empty && mem_sdram_ready;
    assign download_rise = ioctl_download && !download_d_reg;
    // Same-width add: the offset wraps modulo 2^ADDR_W by construction.
    assign push_addr     = BASE_ADDR + ioctl_addr;

    // Storage needs no reset; emptiness is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {push_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            timer_reg      <= '0;
            download_d_reg <= 1'b0;
            ioctl_wait     <= 1'b0;
            upload         <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            mem_rnw        <= 1'b1;
            mem_ram_cs     <= 1'b0;
            bytes_written  <= '0;
            overflow_err   <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            download_d_reg <= ioctl_download;
            ioctl_wait     <= (count_reg >= HIGH_WATER);

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            if (ioctl_wr && ioctl_download && fifo_full) begin
                overflow_err <= 1'b1;
            end

            if (download_rise) begin
                upload <= 1'b1;
            end else if (!ioctl_download && fifo_empty && (state_reg == IDLE)) begin
                upload <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        {mem_addr, mem_data} <= fifo_mem[rd_ptr_reg];
                        mem_ram_cs <= 1'b1;
                        mem_rnw    <= 1'b0;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    mem_ram_cs <= 1'b0;
                    mem_rnw    <= 1'b1;
                    timer_reg  <= '0;
                    state_reg  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mem_sdram_done) begin
                        bytes_written <= bytes_written + 1'b1;
                        state_reg     <= IDLE;
                    end else if (timer_reg == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A fresh download restarts the byte count even if a write completes now.
            if (download_rise) begin
                bytes_written <= '0;
            end
        end
    end

endmodule

// File: tb/tb_upload_loader.sv
// Randomized and directed bench for upload_loader with a queue-based reference model.
module tb_upload_loader;

    localparam int          AW    = 27;
    localparam logic [26:0] BASE  = 27'h7FFFFFF;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          ioctl_wr = 1'b0;
    logic          ioctl_wait;
    logic          upload;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_rnw;
    logic          mem_ram_cs;
    logic          mem_sdram_ready = 1'b0;
    logic          mem_sdram_done = 1'b0;
    logic [AW-1:0] bytes_written;
    logic          overflow_err;
    logic          timeout_err;

    upload_loader #(
        .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
        .upload(upload), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_rnw(mem_rnw), .mem_ram_cs(mem_ram_cs),
        .mem_sdram_ready(mem_sdram_ready), .mem_sdram_done(mem_sdram_done),
        .bytes_written(bytes_written), .overflow_err(overflow_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory responder: 0 = random done level, 1 = done two cycles after cs, 2 = never.
    int done_mode = 0;
    int cs_age = 1000;
    always @(negedge clk) begin
        if (mem_ram_cs) cs_age = 0;
        else if (cs_age < 1000) cs_age++;
        case (done_mode)
            0:       mem_sdram_done = ($urandom_range(0, 3) == 0);
            1:       mem_sdram_done = (cs_age == 2);
            default: mem_sdram_done = 1'b0;
        endcase
    end

    // Reference model: byte queue plus memory-side phase (0 idle, 1 request, 2 waiting).
    logic [34:0]   q[$];
    logic [26:0]   pop_log[$];
    int            cs_pulses = 0;
    int            m_ph = 0, m_pre_ph = 0, m_wcnt = 0, m_sz = 0;
    logic          m_up = 0, m_prev_dl = 0, m_ovf = 0, m_tmo = 0, m_wait = 0, m_pop = 0;
    logic [26:0]   m_bw = '0, m_addr = '0;
    logic [7:0]    m_data = '0;
    logic [34:0]   m_head;
    longint        m_sum;

    always @(posedge clk) begin
        if (!reset_n) begin
            q.delete();
            m_ph = 0; m_wcnt = 0; m_up = 0; m_prev_dl = 0; m_ovf = 0; m_tmo = 0;
            m_wait = 0; m_bw = '0; m_addr = '0; m_data = '0;
        end else begin
            m_sz     = q.size();
            m_pre_ph = m_ph;
            m_pop    = (m_ph == 0) && m_up && (m_sz > 0) && mem_sdram_ready;
            m_wait   = (m_sz >= DEPTH - 1);
            if (m_ph == 1) begin
                m_ph = 2; m_wcnt = 1;
            end else if (m_ph == 2) begin
                if (mem_sdram_done) begin
                    m_bw = m_bw + 27'd1; m_ph = 0;
                end else if (m_wcnt == TMO) begin
                    m_tmo = 1; m_ph = 0;
                end else begin
                    m_wcnt++;
                end
            end
            if (m_pop) begin
                m_head = q.pop_front();
                m_addr = m_head[34:8];
                m_data = m_head[7:0];
                m_ph   = 1;
            end
            if (ioctl_download && ioctl_wr) begin
                if (m_sz < DEPTH) begin
                    m_sum = (longint'(BASE) + longint'(ioctl_addr)) % (longint'(1) << AW);
                    q.push_back({m_sum[26:0], ioctl_dout});
                end else begin
                    m_ovf = 1;
                end
            end
            if (ioctl_download && !m_prev_dl) begin
                m_up = 1; m_bw = '0;
            end else if (!ioctl_download && m_sz == 0 && m_pre_ph == 0) begin
                m_up = 0;
            end
            m_prev_dl = ioctl_download;
        end
        #1;
        check_val("mem_ram_cs", mem_ram_cs, m_ph == 1);
        check_val("mem_rnw", mem_rnw, m_ph != 1);
        check_val("mem_addr", mem_addr, m_addr);
        check_val("mem_data", mem_data, m_data);
        check_val("upload", upload, m_up);
        check_val("ioctl_wait", ioctl_wait, m_wait);
        check_val("bytes_written", bytes_written, m_bw);
        check_val("overflow_err", overflow_err, m_ovf);
        check_val("timeout_err", timeout_err, m_tmo);
        if (mem_ram_cs) begin
            cs_pulses++;
            pop_log.push_back(mem_addr);
            $display("TXN %0d write addr=%07h data=%02h t=%0t", cs_pulses, mem_addr, mem_data, $time);
        end
    end

    task automatic wait_upload_low(input int maxc);
        int c = 0;
        while (upload && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check_val("upload_falls", upload, 0);
    endtask

    task automatic send_bytes(input int n, input int a0);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (!ioctl_wait) begin
                ioctl_wr = 1'b1; ioctl_addr = AW'(a0 + k); ioctl_dout = 8'(a0 + k); k++;
            end else begin
                ioctl_wr = 1'b0;
            end
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cs;
        int c;
        logic seen;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_upload", upload, 0);
        check_val("rst_cs", mem_ram_cs, 0);
        check_val("rst_rnw", mem_rnw, 1);
        check_val("rst_wait", ioctl_wait, 0);
        check_val("rst_bw", bytes_written, 0);
        reset_n = 1'b1;

        // 16-byte download, addresses wrap past the top of memory
        done_mode = 1; mem_sdram_ready = 1'b1;
        pop_log.delete(); base_cs = cs_pulses;
        @(negedge clk); ioctl_download = 1'b1;
        send_bytes(16, 0);
        ioctl_download = 1'b0;
        wait_upload_low(400);
        check_val("t1_pulses", cs_pulses - base_cs, 16);
        check_val("t1_bw", bytes_written, 16);
        check_val("t1_log_size", pop_log.size(), 16);
        check_val("t1_addr0", pop_log[0], 27'h7FFFFFF);
        check_val("t1_addr1_wrap", pop_log[1], 0);
        check_val("t1_addr15", pop_log[15], 14);

        // Overflow with the controller stalled
        mem_sdram_ready = 1'b0; base_cs = cs_pulses;
        @(negedge clk); ioctl_download = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check_val("t2_wait_full", ioctl_wait, 1);
                check_val("t2_no_ovf_yet", overflow_err, 0);
            end
            ioctl_wr = 1'b1; ioctl_addr = AW'(200 + i); ioctl_dout = 8'(i);
        end
        @(negedge clk); ioctl_wr = 1'b0;
        check_val("t2_ovf", overflow_err, 1);
        mem_sdram_ready = 1'b1; ioctl_download = 1'b0;
        wait_upload_low(400);
        check_val("t2_pulses", cs_pulses - base_cs, 4);
        check_val("t2_bw", bytes_written, 4);

        // Push and pop on the same edge at count 2
        mem_sdram_ready = 1'b0;
        @(negedge clk); ioctl_download = 1'b1;
        @(negedge clk); ioctl_wr = 1'b1; ioctl_addr = AW'(100); ioctl_dout = 8'hA0;
        @(negedge clk); ioctl_addr = AW'(101); ioctl_dout = 8'hA1;
        @(negedge clk); ioctl_wr = 1'b0;
        @(negedge clk); mem_sdram_ready = 1'b1; ioctl_wr = 1'b1; ioctl_addr = AW'(102); ioctl_dout = 8'hA2;
        @(negedge clk); mem_sdram_ready = 1'b0; ioctl_wr = 1'b0;
        check_val("t3_wait_a", ioctl_wait, 0);
        @(negedge clk);
        check_val("t3_wait_b", ioctl_wait, 0);
        mem_sdram_ready = 1'b1; ioctl_download = 1'b0;
        wait_upload_low(400);
        check_val("t3_bw", bytes_written, 3);

        // Timeout with no completion
        done_mode = 2; base_cs = cs_pulses;
        @(negedge clk); ioctl_download = 1'b1;
        @(negedge clk); ioctl_wr = 1'b1; ioctl_addr = AW'(300); ioctl_dout = 8'h55;
        @(negedge clk); ioctl_wr = 1'b0; ioctl_download = 1'b0;
        c = 0;
        while (!timeout_err && c < 400) begin @(negedge clk); c++; end
        check_val("t4_tmo", timeout_err, 1);
        check_val("t4_bw", bytes_written, 0);
        wait_upload_low(10);
        check_val("t4_pulses", cs_pulses - base_cs, 1);

        // Reset while a request is on the bus
        @(negedge clk); ioctl_download = 1'b1;
        @(negedge clk); ioctl_wr = 1'b1; ioctl_addr = AW'(400); ioctl_dout = 8'h77;
        @(negedge clk); ioctl_wr = 1'b0;
        seen = 1'b0; c = 0;
        while (!seen && c < 20) begin
            @(posedge clk); #1;
            seen = mem_ram_cs; c++;
        end
        check_val("t5_cs_seen", seen, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("t5_cs", mem_ram_cs, 0);
        check_val("t5_rnw", mem_rnw, 1);
        check_val("t5_upload", upload, 0);
        check_val("t5_addr", mem_addr, 0);
        check_val("t5_data", mem_data, 0);
        check_val("t5_tmo", timeout_err, 0);
        check_val("t5_ovf", overflow_err, 0);
        check_val("t5_wait", ioctl_wait, 0);
        @(negedge clk); ioctl_download = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        done_mode = 1;
        @(negedge clk); ioctl_download = 1'b1;
        send_bytes(3, 500);
        ioctl_download = 1'b0;
        wait_upload_low(200);
        check_val("t5_bw_after", bytes_written, 3);

        // Random traffic against the model
        done_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) ioctl_download = ~ioctl_download;
            mem_sdram_ready = ($urandom_range(0, 3) != 0);
            ioctl_addr = AW'($urandom);
            ioctl_dout = 8'($urandom);
            ioctl_wr = ($urandom_range(0, 1) == 1) && (!ioctl_wait || $urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        ioctl_wr = 1'b0; ioctl_download = 1'b0; mem_sdram_ready = 1'b1; done_mode = 1;
        wait_upload_low(500);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
